// File: rtl/dm_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state encoding, the default DEPTH / WAIT_STATES constants,
// the wait counter width and the address error check.
package dm_pkg;

  localparam int DM_DEPTH_DEF       = 64;
  localparam int DM_WAIT_STATES_DEF = 2;
  localparam int DM_CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } dm_state_e;

  // Misaligned byte address, or word index beyond the array. The full 30-bit
  // word index is compared so high address bits never alias onto real words.
  function automatic logic dm_addr_err(input logic [31:0] addr,
                                       input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dm_wait_counter.sv
// Down-counter that times the wait phase of the responder.
// Ports:
//   clk, rst  : parent clock and synchronous active-high reset
//   load      : load load_val this cycle (has priority over decrement)
//   load_val  : value to load
//   dec_en    : decrement by one; holds at zero
//   zero      : counter currently equals zero
module dm_wait_counter
  import dm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DM_CNT_W-1:0] load_val,
  input  logic                dec_en,
  output logic                zero
);

  logic [DM_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a register-array memory with a
// fixed, parameterised response latency of WAIT_STATES+1 cycles.
// Ports:
//   clk_DataMem, rst_DataMem : clock, synchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata : request from initiator
//   req_ready  : high only while idle; request accepted on valid & ready
//   resp_valid : one-cycle response pulse
//   resp_rdata : load data (0 for stores and errors)
//   resp_err   : misaligned or out-of-range access
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int DEPTH       = DM_DEPTH_DEF,
  parameter int WAIT_STATES = DM_WAIT_STATES_DEF
) (
  input  logic        clk_DataMem,
  input  logic        rst_DataMem,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [DM_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? DM_CNT_W'(WAIT_STATES - 1) : '0;

  dm_state_e   state;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             sel_write;
  logic [31:0]      sel_addr;
  logic             sel_err;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      load_data;

  assign accept   = (state == IDLE) && req_valid;
  assign cnt_load = accept && !NO_WAIT;
  assign cnt_dec  = (state == WAIT);

  dm_wait_counter u_wait_counter (
    .clk      (clk_DataMem),
    .rst      (rst_DataMem),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec_en   (cnt_dec),
    .zero     (cnt_zero)
  );

  // With no wait states the response is produced on the acceptance edge, so
  // the request being latched is taken straight from the inputs; otherwise
  // the already latched request drives the response and the memory write.
  always_comb begin
    if (state == IDLE) begin
      sel_write = req_write;
      sel_addr  = req_addr;
    end else begin
      sel_write = lat_write;
      sel_addr  = lat_addr;
    end
    sel_err   = dm_addr_err(sel_addr, DEPTH);
    sel_idx   = sel_addr[IDX_W+1:2];
    load_data = (sel_err || sel_write) ? '0 : mem[sel_idx];
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk_DataMem) begin
    if (rst_DataMem) begin
      state      <= IDLE;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (NO_WAIT) begin
              state      <= RESPOND;
              resp_valid <= 1'b1;
              resp_err   <= sel_err;
              resp_rdata <= load_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            state      <= RESPOND;
            resp_valid <= 1'b1;
            resp_err   <= sel_err;
            resp_rdata <= load_data;
          end
        end
        RESPOND: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage: legal stores commit on the edge leaving RESPOND
  always_ff @(posedge clk_DataMem) begin
    if (rst_DataMem) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((state == RESPOND) && sel_write && !sel_err) begin
      mem[sel_idx] <= lat_wdata;
    end
  end

endmodule
